// File: rtl/altr_hps_rr_arb.sv
// altr_hps_rr_arb: round-robin arbiter with registered one-hot grant,
// hold-until-release ownership and an optional hold-time preemption limit.
//
// Ports:
//   clk       - clock, all logic on the rising edge
//   rst       - synchronous active-high reset
//   req       - level request per requester, held while using the resource
//   gnt       - registered one-hot grant
//   gnt_valid - registered OR of gnt
//   gnt_id    - registered index of the owner (0 when idle)
//   any_req   - combinational OR of req, for upstream clock/power gating
module altr_hps_rr_arb #(
  parameter int NUM_REQ  = 4,
  parameter int ID_W     = 2,
  parameter int HOLD_MAX = 16,
  parameter int CNT_W    = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_valid,
  output logic [ID_W-1:0]    gnt_id,
  output logic               any_req
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  localparam bit HOLD_EN = (HOLD_MAX != 0);
  localparam logic [CNT_W-1:0] HOLD_LAST =
    HOLD_EN ? CNT_W'(HOLD_MAX - 1) : '0;
  localparam logic [ID_W:0] NREQ = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0] LAST_RST = ID_W'(NUM_REQ - 1);

  logic [0:0]         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               gnt_valid_q, gnt_valid_d;
  logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
  logic [ID_W-1:0]    last_ptr_q, last_ptr_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;

  logic               found;
  logic [ID_W-1:0]    win_id;
  logic [ID_W:0]      sum;
  logic               own_req;
  logic               others;
  logic               at_limit;

  assign any_req = |req;

  // Scan last_ptr+1 .. last_ptr+NUM_REQ (mod NUM_REQ); first hit wins,
  // so the previous owner is checked last.
  always_comb begin
    found  = 1'b0;
    win_id = '0;
    sum    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      sum = {1'b0, last_ptr_q} + (ID_W+1)'(k);
      if (sum >= NREQ) sum = sum - NREQ;
      if (!found && req[sum[ID_W-1:0]]) begin
        found  = 1'b1;
        win_id = sum[ID_W-1:0];
      end
    end
  end

  assign own_req  = req[gnt_id_q];
  assign others   = |(req & ~gnt_q);
  assign at_limit = HOLD_EN && (hold_cnt_q == HOLD_LAST);

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_valid_d = gnt_valid_q;
    gnt_id_d    = gnt_id_q;
    last_ptr_d  = last_ptr_q;
    hold_cnt_d  = hold_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d     = GRANT;
          gnt_d       = NUM_REQ'(1) << win_id;
          gnt_valid_d = 1'b1;
          gnt_id_d    = win_id;
          last_ptr_d  = win_id;
          hold_cnt_d  = '0;
        end
      end
      GRANT: begin
        // Release and preemption both return to IDLE, giving one dead
        // cycle between owners for the downstream mux to settle.
        if (!own_req || (at_limit && others)) begin
          state_d     = IDLE;
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          gnt_id_d    = '0;
          hold_cnt_d  = '0;
        end else if (HOLD_EN && !at_limit) begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d     = IDLE;
        gnt_d       = '0;
        gnt_valid_d = 1'b0;
        gnt_id_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_id_q    <= '0;
      last_ptr_q  <= LAST_RST;
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_id_q    <= gnt_id_d;
      last_ptr_q  <= last_ptr_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign gnt_id    = gnt_id_q;

endmodule

// File: tb/tb_altr_hps_rr_arb.sv
// tb_altr_hps_rr_arb: directed vector table plus hand-written
// preemption, long-hold, reset and random fairness sequences.
module tb_altr_hps_rr_arb;

  localparam int N     = 4;
  localparam int HOLD  = 16;
  localparam int BOUND = (N-1)*(HOLD+1)+1;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic         gnt_valid;
  logic [1:0]   gnt_id;
  logic         any_req;

  int errors = 0;
  int checks = 0;

  altr_hps_rr_arb #(
    .NUM_REQ (N),
    .ID_W    (2),
    .HOLD_MAX(HOLD),
    .CNT_W   (5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .gnt      (gnt),
    .gnt_valid(gnt_valid),
    .gnt_id   (gnt_id),
    .any_req  (any_req)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic [1:0]   id;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] idx_of(input logic [N-1:0] g);
    logic [1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) if (g[i]) r = 2'(i);
    return r;
  endfunction

  // Called at a negedge: drive, check any_req, clock once, check grant.
  task automatic step(input string nm, input logic r_rst,
                      input logic [N-1:0] r, input logic [N-1:0] eg);
    rst = r_rst;
    req = r;
    #1;
    chk({nm, "_any"}, 32'(any_req), 32'(|r));
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk({nm, "_gnt"}, 32'(gnt), 32'(eg));
    chk({nm, "_vld"}, 32'(gnt_valid), 32'(|eg));
    chk({nm, "_id"}, 32'(gnt_id), 32'(idx_of(eg)));
  endtask

  task automatic add(input logic r_rst, input logic [N-1:0] r,
                     input logic [N-1:0] g, input logic [1:0] id);
    vec_t v;
    v.rst = r_rst;
    v.req = r;
    v.gnt = g;
    v.id  = id;
    vecs.push_back(v);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int cnt;
    int wait_c[N];
    logic [N-1:0] r;

    rst = 1'b1;
    req = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_vld", 32'(gnt_valid), 32'h0);
    chk("rst_id", 32'(gnt_id), 32'h0);

    // single requester, release
    add(0, 4'b0010, 4'b0010, 1);
    add(0, 4'b0010, 4'b0010, 1);
    add(0, 4'b0010, 4'b0010, 1);
    add(0, 4'b0010, 4'b0010, 1);
    add(0, 4'b0000, 4'b0000, 0);
    add(0, 4'b0000, 4'b0000, 0);
    // round robin 0,1,2,3,0 with release after 3 grant cycles
    add(1, 4'b0000, 4'b0000, 0);
    add(0, 4'b1111, 4'b0001, 0);
    add(0, 4'b1111, 4'b0001, 0);
    add(0, 4'b1111, 4'b0001, 0);
    add(0, 4'b1110, 4'b0000, 0);
    add(0, 4'b1111, 4'b0010, 1);
    add(0, 4'b1111, 4'b0010, 1);
    add(0, 4'b1111, 4'b0010, 1);
    add(0, 4'b1101, 4'b0000, 0);
    add(0, 4'b1111, 4'b0100, 2);
    add(0, 4'b1111, 4'b0100, 2);
    add(0, 4'b1111, 4'b0100, 2);
    add(0, 4'b1011, 4'b0000, 0);
    add(0, 4'b1111, 4'b1000, 3);
    add(0, 4'b1111, 4'b1000, 3);
    add(0, 4'b1111, 4'b1000, 3);
    add(0, 4'b0111, 4'b0000, 0);
    add(0, 4'b1111, 4'b0001, 0);
    add(0, 4'b0000, 4'b0000, 0);
    add(0, 4'b0000, 4'b0000, 0);

    foreach (vecs[i]) begin
      rst = vecs[i].rst;
      req = vecs[i].req;
      #1;
      chk($sformatf("v%0d_any", i), 32'(any_req), 32'(|vecs[i].req));
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk($sformatf("v%0d_gnt", i), 32'(gnt), 32'(vecs[i].gnt));
      chk($sformatf("v%0d_vld", i), 32'(gnt_valid), 32'(|vecs[i].gnt));
      chk($sformatf("v%0d_id", i), 32'(gnt_id), 32'(vecs[i].id));
    end

    // preemption after exactly HOLD grant cycles
    do_reset();
    step("pre_g", 1'b0, 4'b0100, 4'b0100);
    for (int k = 0; k < 4; k++) step("pre_h", 1'b0, 4'b0100, 4'b0100);
    cnt = 5;
    for (int k = 0; k < 40 && gnt == 4'b0100; k++) begin
      req = 4'b0101;
      @(posedge clk);
      @(negedge clk);
      if (gnt == 4'b0100) cnt++;
    end
    chk("pre_len", 32'(cnt), 32'(HOLD));
    chk("pre_gap", 32'(gnt), 32'h0);
    step("pre_new", 1'b0, 4'b0101, 4'b0001);
    step("pre_rel", 1'b0, 4'b0100, 4'b0000);
    step("pre_back", 1'b0, 4'b0100, 4'b0100);

    // uncontested owner holds indefinitely, then preempted at once
    do_reset();
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      req = 4'b1000;
      @(posedge clk);
      @(negedge clk);
      if (gnt == 4'b1000) cnt++;
    end
    chk("long_hold", 32'(cnt), 32'd40);
    step("long_drop", 1'b0, 4'b1010, 4'b0000);
    step("long_new", 1'b0, 4'b1010, 4'b0010);

    // reset mid-grant
    do_reset();
    step("mr_g2", 1'b0, 4'b0100, 4'b0100);
    step("mr_h", 1'b0, 4'b0101, 4'b0100);
    step("mr_rst", 1'b1, 4'b0101, 4'b0000);
    step("mr_after", 1'b0, 4'b0101, 4'b0001);

    // random traffic: owners release at random, waiters hold their request
    do_reset();
    r = '0;
    for (int i = 0; i < N; i++) wait_c[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (r[i] && gnt[i] && ($urandom % 4 == 0)) r[i] = 1'b0;
        else if (!r[i] && ($urandom % 3 == 0)) r[i] = 1'b1;
      end
      req = r;
      @(posedge clk);
      @(negedge clk);
      chk("rnd_onehot", 32'($onehot0(gnt)), 32'd1);
      chk("rnd_vld", 32'(gnt_valid), 32'(|gnt));
      if (gnt != 0) chk("rnd_id", 32'(gnt[gnt_id]), 32'd1);
      for (int i = 0; i < N; i++) begin
        if (r[i] && !gnt[i]) wait_c[i]++;
        else wait_c[i] = 0;
        if (wait_c[i] > BOUND) begin
          chk($sformatf("rnd_wait%0d", i), 32'(wait_c[i]), 32'(BOUND));
          wait_c[i] = 0;
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
